// File: rtl/fsm_pkg.sv
// Shared constants and the elaboration-time KMP next-state function for the
// serial pattern detector.
package fsm_pkg;

   localparam int LEN_MAX     = 8;
   localparam int STATE_W_MAX = $clog2(LEN_MAX);

   typedef logic [STATE_W_MAX-1:0] state_max_t;

   // Next matched-prefix length after receiving bit b with s bits already
   // matched: the longest proper prefix of the pattern that is a suffix of
   // (matched prefix, b). Without overlap, a completed match restarts at 0.
   function automatic state_max_t kmp_next(input logic [LEN_MAX-1:0] pat,
                                           input int                 len,
                                           input int                 s,
                                           input logic               b,
                                           input bit                 overlap);
      state_max_t res;
      bit         ok;
      int         j;
      logic       c;
      res = '0;
      if (!overlap && (s == len - 1) && (b == pat[0])) begin
         return '0;
      end
      for (int k = 1; (k < len) && (k <= s + 1); k++) begin
         ok = 1'b1;
         for (int i = 0; i < k; i++) begin
            j = s + 1 - k + i;
            c = (j == s) ? b : pat[STATE_W_MAX'(len - 1 - j)];
            if (c != pat[STATE_W_MAX'(len - 1 - i)]) begin
               ok = 1'b0;
            end
         end
         if (ok) begin
            res = state_max_t'(k);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector (Mealy, KMP fallback). Macro SEQ_DET_CNT_EN
// adds the saturating match counter with its cnt_clr/match_cnt ports.
module seq_detector
   import fsm_pkg::*;
#(
   parameter int             LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1011,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x_valid,
   input  logic             x,
`ifdef SEQ_DET_CNT_EN
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] match_cnt,
`endif
   output logic             y
);

   localparam int                 SW      = $clog2(LEN);
   localparam logic [LEN_MAX-1:0] PAT_EXT = LEN_MAX'(PATTERN);

   if ((LEN < 2) || (LEN > LEN_MAX) || (CNT_W < 1)) begin : g_bad_params
      $error("seq_detector: LEN must be 2..8 and CNT_W at least 1");
   end

   logic [SW-1:0] state;
   logic [SW-1:0] state_next;
   logic [SW-1:0] nxt0 [LEN];
   logic [SW-1:0] nxt1 [LEN];
   logic          legal;

   // Transition table, one entry per (state, received bit), fixed at elaboration.
   for (genvar g = 0; g < LEN; g++) begin : g_tab
      localparam state_max_t N0 = kmp_next(PAT_EXT, LEN, g, 1'b0, OVERLAP);
      localparam state_max_t N1 = kmp_next(PAT_EXT, LEN, g, 1'b1, OVERLAP);
      assign nxt0[g] = N0[SW-1:0];
      assign nxt1[g] = N1[SW-1:0];
   end

   if ((1 << SW) == LEN) begin : g_full_code
      assign legal = 1'b1;
   end else begin : g_part_code
      assign legal = (state < SW'(LEN));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= '0;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      y          = 1'b0;
      if (!legal) begin
         state_next = '0;
      end else if (x_valid) begin
         state_next = x ? nxt1[state] : nxt0[state];
         y          = (state == SW'(LEN - 1)) && (x == PATTERN[0]);
      end
   end

`ifdef SEQ_DET_CNT_EN
   sat_counter #(
      .W(CNT_W)
   ) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(cnt_clr),
      .inc(y),
      .cnt(match_cnt)
   );
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: overlapping, non-overlapping and 2-bit-counter
// instances share one stimulus stream; a window-compare model feeds a scoreboard.
module tb_seq_detector;

   localparam int         L = 4;
   localparam logic [3:0] P = 4'b1011;

   logic clk = 1'b0;
   logic rst;
   logic x_valid;
   logic x;
   logic cnt_clr;
   logic y_ov, y_nov, y_c2;
`ifdef SEQ_DET_CNT_EN
   logic [7:0] cnt_ov, cnt_nov;
   logic [1:0] cnt_c2;
`endif

   seq_detector #(.LEN(L), .PATTERN(P), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
`ifdef SEQ_DET_CNT_EN
      .cnt_clr(cnt_clr), .match_cnt(cnt_ov),
`endif
      .y(y_ov)
   );

   seq_detector #(.LEN(L), .PATTERN(P), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
`ifdef SEQ_DET_CNT_EN
      .cnt_clr(cnt_clr), .match_cnt(cnt_nov),
`endif
      .y(y_nov)
   );

   seq_detector #(.LEN(L), .PATTERN(P), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
`ifdef SEQ_DET_CNT_EN
      .cnt_clr(cnt_clr), .match_cnt(cnt_c2),
`endif
      .y(y_c2)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic ov;
      logic nov;
   } exp_t;
   exp_t q[$];

   logic [7:0]  hist;
   int          since_ov, since_nov;
   int          m_ov, m_nov, m_c2;
   logic [15:0] tr_ov, tr_nov;

   task automatic model_reset();
      hist      = '0;
      since_ov  = 0;
      since_nov = 0;
      m_ov      = 0;
      m_nov     = 0;
      m_c2      = 0;
      tr_ov     = '0;
      tr_nov    = '0;
      q.delete();
   endtask

   // One bit per cycle: inputs change on the falling edge, outputs are
   // sampled 2 time units later, the DUT acts on the following rising edge.
   task automatic drive(input logic v, input logic b, input logic c);
      exp_t       e;
      logic [3:0] win;
      @(negedge clk);
      x_valid = v;
      x       = b;
      cnt_clr = c;
      win     = {hist[2:0], b};
      e.ov    = v && (since_ov  >= L - 1) && (win == P);
      e.nov   = v && (since_nov >= L - 1) && (win == P);
      q.push_back(e);
      #2;
      e = q.pop_front();
      checks++;
      if (y_ov !== e.ov) begin
         errors++;
         $display("FAIL y_ov t=%0t got=%0b exp=%0b", $time, y_ov, e.ov);
      end
      checks++;
      if (y_nov !== e.nov) begin
         errors++;
         $display("FAIL y_nov t=%0t got=%0b exp=%0b", $time, y_nov, e.nov);
      end
      checks++;
      if (y_c2 !== e.ov) begin
         errors++;
         $display("FAIL y_c2 t=%0t got=%0b exp=%0b", $time, y_c2, e.ov);
      end
      tr_ov  = {tr_ov[14:0], y_ov};
      tr_nov = {tr_nov[14:0], y_nov};
`ifdef SEQ_DET_CNT_EN
      checks++;
      if (cnt_ov !== 8'(m_ov)) begin
         errors++;
         $display("FAIL cnt_ov t=%0t got=%0d exp=%0d", $time, cnt_ov, m_ov);
      end
      checks++;
      if (cnt_nov !== 8'(m_nov)) begin
         errors++;
         $display("FAIL cnt_nov t=%0t got=%0d exp=%0d", $time, cnt_nov, m_nov);
      end
      checks++;
      if (cnt_c2 !== 2'(m_c2)) begin
         errors++;
         $display("FAIL cnt_c2 t=%0t got=%0d exp=%0d", $time, cnt_c2, m_c2);
      end
`endif
      if (c) begin
         m_ov  = 0;
         m_nov = 0;
         m_c2  = 0;
      end else begin
         if (e.ov  && (m_ov  < 255)) m_ov++;
         if (e.nov && (m_nov < 255)) m_nov++;
         if (e.ov  && (m_c2  < 3))   m_c2++;
      end
      if (v) begin
         hist      = {hist[6:0], b};
         since_ov  = since_ov + 1;
         since_nov = e.nov ? 0 : since_nov + 1;
      end
   endtask

   // Reset asserted between edges with a would-be final bit on x, so a partial
   // match that survived reset would show up on y immediately.
   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      x_valid = 1'b1;
      x       = P[0];
      cnt_clr = 1'b0;
      #2;
      checks++;
      if ((y_ov !== 1'b0) || (y_nov !== 1'b0) || (y_c2 !== 1'b0)) begin
         errors++;
         $display("FAIL rst_y got=%0b%0b%0b exp=000", y_ov, y_nov, y_c2);
      end
`ifdef SEQ_DET_CNT_EN
      checks++;
      if ((cnt_ov !== 8'd0) || (cnt_nov !== 8'd0) || (cnt_c2 !== 2'd0)) begin
         errors++;
         $display("FAIL rst_cnt got=%0d/%0d/%0d exp=0", cnt_ov, cnt_nov, cnt_c2);
      end
`endif
      @(negedge clk);
      x_valid = 1'b0;
      x       = 1'b0;
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ((y_ov !== 1'b0) || (y_nov !== 1'b0)) begin
         errors++;
         $display("FAIL init_y got=%0b%0b exp=00", y_ov, y_nov);
      end
`ifdef SEQ_DET_CNT_EN
      checks++;
      if (cnt_ov !== 8'd0) begin
         errors++;
         $display("FAIL init_cnt got=%0d exp=0", cnt_ov);
      end
`endif
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      drive(1, 1, 0); drive(1, 0, 0); drive(1, 1, 0); drive(1, 1, 0);
      checks++;
      if (tr_ov[3:0] !== 4'b0001) begin
         errors++;
         $display("FAIL basic_trace got=%b exp=0001", tr_ov[3:0]);
      end
      drive(0, 0, 0);
`ifdef SEQ_DET_CNT_EN
      checks++;
      if (cnt_ov !== 8'd1) begin
         errors++;
         $display("FAIL basic_cnt got=%0d exp=1", cnt_ov);
      end
`endif
   endtask

   task automatic test_overlap();
      logic [6:0] bits;
      bits = 7'b1011011;
      do_reset();
      for (int i = 6; i >= 0; i--) drive(1, bits[i], 0);
      checks++;
      if (tr_ov[6:0] !== 7'b0001001) begin
         errors++;
         $display("FAIL overlap_trace got=%b exp=0001001", tr_ov[6:0]);
      end
      checks++;
      if (tr_nov[6:0] !== 7'b0001000) begin
         errors++;
         $display("FAIL nonoverlap_trace got=%b exp=0001000", tr_nov[6:0]);
      end
      drive(0, 0, 0);
`ifdef SEQ_DET_CNT_EN
      checks++;
      if ((cnt_ov !== 8'd2) || (cnt_nov !== 8'd1)) begin
         errors++;
         $display("FAIL overlap_cnt got=%0d/%0d exp=2/1", cnt_ov, cnt_nov);
      end
`endif
   endtask

   task automatic test_fallback();
      logic [5:0] bits;
      bits = 6'b101011;
      do_reset();
      for (int i = 5; i >= 0; i--) drive(1, bits[i], 0);
      checks++;
      if (tr_ov[5:0] !== 6'b000001) begin
         errors++;
         $display("FAIL fallback_trace got=%b exp=000001", tr_ov[5:0]);
      end
   endtask

   task automatic test_gaps();
      do_reset();
      drive(1, 1, 0); drive(1, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0);
      drive(1, 1, 0); drive(1, 1, 0);
      checks++;
      if (tr_ov[6:0] !== 7'b0000001) begin
         errors++;
         $display("FAIL gaps_trace got=%b exp=0000001", tr_ov[6:0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] pre;
      do_reset();
      drive(1, 1, 0); drive(1, 0, 0); drive(1, 1, 0);
      pre = tr_ov[3:0];
      do_reset();
      drive(1, 1, 0);
      checks++;
      if ({pre[2:0], tr_ov[0]} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid_trace got=%b exp=0000", {pre[2:0], tr_ov[0]});
      end
      drive(0, 0, 0);
`ifdef SEQ_DET_CNT_EN
      checks++;
      if (cnt_ov !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid_cnt got=%0d exp=0", cnt_ov);
      end
`endif
   endtask

   task automatic test_counter();
      do_reset();
      for (int n = 0; n < 5; n++) begin
         drive(1, 1, 0); drive(1, 0, 0); drive(1, 1, 0); drive(1, 1, 0);
      end
      drive(0, 0, 0);
`ifdef SEQ_DET_CNT_EN
      checks++;
      if ((cnt_c2 !== 2'd3) || (cnt_ov !== 8'd5)) begin
         errors++;
         $display("FAIL sat_cnt got=%0d/%0d exp=3/5", cnt_c2, cnt_ov);
      end
`endif
      drive(1, 1, 0); drive(1, 0, 0); drive(1, 1, 0); drive(1, 1, 1);
      checks++;
      if (tr_ov[0] !== 1'b1) begin
         errors++;
         $display("FAIL clr_match got=%b exp=1", tr_ov[0]);
      end
      drive(0, 0, 0);
`ifdef SEQ_DET_CNT_EN
      checks++;
      if ((cnt_c2 !== 2'd0) || (cnt_ov !== 8'd0)) begin
         errors++;
         $display("FAIL clr_prio got=%0d/%0d exp=0/0", cnt_c2, cnt_ov);
      end
`endif
   endtask

   task automatic test_random();
      logic [3:0] pat;
      pat = P;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 3; i >= 0; i--) drive(1, pat[i], 0);
         end else begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 40) == 0));
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      x_valid = 1'b0;
      x       = 1'b0;
      cnt_clr = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_overlap();
      test_fallback();
      test_gaps();
      test_reset_mid();
      test_counter();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL have parameter LEN, default 4, the pattern length in bits; legal range 2..8.
REQ-002 SHALL have parameter PATTERN, default 4'b1011, the [LEN-1:0] pattern; PATTERN[LEN-1] is received first.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 SHALL have parameter CNT_W, default 8, the match counter width.
REQ-005 SHALL have port clk, input, 1, the single clock; all flops on posedge.
REQ-006 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port x_valid, input, 1; x is sampled only when high.
REQ-008 SHALL have port x, input, 1, the serial data bit.
REQ-009 SHALL have port cnt_clr, input, 1, synchronous clear of match_cnt.
REQ-010 SHALL have port y, output, 1, the Mealy match flag.
REQ-011 SHALL have port match_cnt, output, CNT_W, the saturating match count; present only under SEQ_DET_CNT_EN.

Function
REQ-012 State SHALL be the number of pattern bits currently matched: 0..LEN-1, encoded in clog2(LEN) bits.
REQ-013 y SHALL be combinational: x_valid && state==LEN-1 && x==PATTERN[0]; no registered latency, so it is asserted in the same cycle as the final bit.
REQ-014 Bit test: the expected bit in state s is PATTERN[LEN-1-s].
- x_valid && expected bit: s -> s+1.
- Final-bit match with OVERLAP=1: next state is fb(LEN), the length of the longest proper prefix of PATTERN that is also a suffix of PATTERN.
- Final-bit match with OVERLAP=0: next state is 0.
REQ-015 On x_valid && mismatch, next state SHALL be the length of the longest proper prefix of PATTERN that is a suffix of (matched prefix followed by x), KMP fallback; it is 0 if there is none.
REQ-016 The fallback/next-state table SHALL be computed at elaboration from PATTERN by a constant function; no hand-written per-pattern tables.
REQ-017 When x_valid is low: state holds, y=0, match_cnt holds; gaps of any length SHALL NOT break a partial match.
REQ-018 Illegal state encodings (>LEN-1) SHALL return to state 0 on the next clk edge with y=0.
REQ-019 match_cnt SHALL increment by 1 on each cycle with y=1 and saturate at 2^CNT_W-1, with no wrap.
REQ-020 cnt_clr SHALL take priority over increment: cnt_clr and y=1 in the same cycle gives match_cnt=0 next cycle.

Reset
REQ-021 While rst=1: state=0, match_cnt=0, y=0 (guaranteed since LEN>=2 means state 0 cannot complete a match).
REQ-022 Asserting rst mid-sequence SHALL discard any partial match immediately, without waiting for a clock edge.
REQ-023 The first valid bit after rst deasserts SHALL be evaluated from state 0.

Configuration
REQ-024 Macro SEQ_DET_CNT_EN defined: the counter, cnt_clr and match_cnt SHALL be compiled in.
REQ-025 SEQ_DET_CNT_EN undefined: match_cnt and cnt_clr ports and the counter logic SHALL be absent; y and state behaviour SHALL be identical.

Structure
REQ-026 Package fsm_pkg SHALL hold the fallback-computing constant function, the LEN_MAX=8 constant, and a typedef for the state width at LEN_MAX.
REQ-027 The saturating counter SHALL be sub-module sat_counter (parameter W; inputs clk, rst, clr, inc; output cnt), instantiated only under SEQ_DET_CNT_EN.

Verification
Default bench config: PATTERN=4'b1011, LEN=4, CNT_W=8, SEQ_DET_CNT_EN defined.
REQ-028 Basic: valid bits 1,0,1,1 -> y=1 only on the 4th bit's cycle; match_cnt=1 next cycle.
REQ-029 Overlap: bits 1,0,1,1,0,1,1.
- OVERLAP=1 -> y on bits 4 and 7; match_cnt=2.
- OVERLAP=0 -> y on bit 4 only; match_cnt=1.
REQ-030 Fallback: bits 1,0,1,0,1,1 -> y only on bit 6 (after the mismatching 0, the state falls back to 2).
REQ-031 Gaps and reset:
- 1,0,[x_valid=0, x=0 for 3 cycles],1,1 -> y on the final bit.
- 1,0,1, then rst pulse, then 1 -> y stays 0.
REQ-032 Counter: CNT_W=2 with 5 matches -> match_cnt=3; then cnt_clr asserted in the same cycle as a match -> match_cnt=0.
REQ-033 Build without SEQ_DET_CNT_EN, rerun REQ-028..REQ-031 -> identical y trace; the match_cnt port is absent.
